// File: rtl/ttc_timer_counter_param3_if.sv
// rtl/ttc_timer_counter_param3_if.sv - register write bus between TTC APB decode and timer
interface ttc_timer_counter_param3_if #(
    parameter int CNT_W = 16
);
    logic             wr_en3;
    logic [2:0]       wr_addr3;
    logic [CNT_W-1:0] pwdata3;

    modport master (output wr_en3, output wr_addr3, output pwdata3);
    modport slave  (input  wr_en3, input  wr_addr3, input  pwdata3);
endinterface

// File: rtl/ttc_timer_counter_param3.sv
// rtl/ttc_timer_counter_param3.sv - parametrised TTC timer/counter with prescaler, match and one-shot
module ttc_timer_counter_param3 #(
    parameter int CNT_W     = 16,
    parameter int NUM_MATCH = 3
) (
    input  logic                       pclk3,
    input  logic                       n_p_reset3,
    ttc_timer_counter_param3_if.slave  bus,
    input  logic                       clear_interrupt3,
    output logic [CNT_W-1:0]           counter_val_reg3,
    output logic [4:0]                 clk_ctrl_reg3,
    output logic [5:0]                 cntr_ctrl_reg3,
    output logic [CNT_W-1:0]           interval_reg3,
    output logic [NUM_MATCH*CNT_W-1:0] match_regs3,
    output logic [NUM_MATCH+1:0]       interrupt_reg3,
    output logic [NUM_MATCH+1:0]       interrupt_en_reg3,
    output logic                       interrupt3
);
    localparam int               ST_W    = NUM_MATCH + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0]                 clk_ctrl_q,  clk_ctrl_d;
    logic [5:0]                 cntr_ctrl_q, cntr_ctrl_d;
    logic [CNT_W-1:0]           interval_q,  interval_d;
    logic [ST_W-1:0]            intr_en_q,   intr_en_d;
    logic [NUM_MATCH*CNT_W-1:0] match_q,     match_d;
    logic [CNT_W-1:0]           count_q,     count_d;
    logic [14:0]                pre_cnt_q,   pre_cnt_d;
    logic [ST_W-1:0]            status_q,    status_d;

    logic                 wr_clk, wr_ctrl, wr_intv, wr_ien, restart;
    logic [NUM_MATCH-1:0] wr_match;
    logic                 enabled, pre_tick, tick;
    logic [14:0]          pre_mask;
    logic [CNT_W-1:0]     cnt_step;
    logic                 step_int, step_ovf;
    logic [NUM_MATCH-1:0] ev_match;
    logic [ST_W-1:0]      events;

    // Address decode of the single-cycle write strobe
    always_comb begin
        wr_clk  = bus.wr_en3 && (bus.wr_addr3 == 3'd0);
        wr_ctrl = bus.wr_en3 && (bus.wr_addr3 == 3'd1);
        wr_intv = bus.wr_en3 && (bus.wr_addr3 == 3'd2);
        wr_ien  = bus.wr_en3 && (bus.wr_addr3 == 3'd3);
        restart = wr_ctrl && bus.pwdata3[4];
        for (int k = 0; k < NUM_MATCH; k++) begin
            wr_match[k] = bus.wr_en3 && (bus.wr_addr3 == 3'(4 + k));
        end
    end

    // Prescaler tick: low N bits of the prescaler all ones (N = 0 gives an empty mask, so every cycle)
    always_comb begin
        enabled  = !cntr_ctrl_q[0];
        pre_mask = ~(15'h7FFF << clk_ctrl_q[4:1]);
        pre_tick = (pre_cnt_q & pre_mask) == pre_mask;
        tick     = enabled && (!clk_ctrl_q[0] || pre_tick);
    end

    // Candidate next count and wrap events for one counting step in the current mode
    always_comb begin
        cnt_step = count_q;
        step_int = 1'b0;
        step_ovf = 1'b0;
        if (cntr_ctrl_q[2]) begin
            if (cntr_ctrl_q[1] && (count_q == '0)) begin
                cnt_step = interval_q;
                step_int = 1'b1;
            end else if (count_q == '0) begin
                cnt_step = CNT_MAX;
                step_ovf = 1'b1;
            end else begin
                cnt_step = count_q - CNT_ONE;
            end
        end else begin
            // A count already past a lowered interval runs on to max and wraps as an overflow
            if (cntr_ctrl_q[1] && (count_q == interval_q)) begin
                cnt_step = '0;
                step_int = 1'b1;
            end else if (count_q == CNT_MAX) begin
                cnt_step = '0;
                step_ovf = 1'b1;
            end else begin
                cnt_step = count_q + CNT_ONE;
            end
        end
        for (int k = 0; k < NUM_MATCH; k++) begin
            ev_match[k] = tick && cntr_ctrl_q[3] && (cnt_step == match_q[k*CNT_W +: CNT_W]);
        end
        events = {tick && step_ovf, ev_match, tick && step_int};
    end

    // Next-state for registers, counter, prescaler and sticky status
    always_comb begin
        clk_ctrl_d  = wr_clk  ? bus.pwdata3[4:0]      : clk_ctrl_q;
        interval_d  = wr_intv ? bus.pwdata3           : interval_q;
        intr_en_d   = wr_ien  ? bus.pwdata3[ST_W-1:0] : intr_en_q;
        match_d     = match_q;
        for (int k = 0; k < NUM_MATCH; k++) begin
            if (wr_match[k]) match_d[k*CNT_W +: CNT_W] = bus.pwdata3;
        end

        // A software write to cntr_ctrl wins over the one-shot hardware disable
        cntr_ctrl_d = cntr_ctrl_q;
        if (wr_ctrl) begin
            cntr_ctrl_d = {bus.pwdata3[5], 1'b0, bus.pwdata3[3:0]};
        end else if (cntr_ctrl_q[5] && (events[0] || events[ST_W-1])) begin
            cntr_ctrl_d[0] = 1'b1;
        end

        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        status_d  = status_q;
        if (restart) begin
            // Reload follows the newly written direction/mode bits
            if (!bus.pwdata3[2])     count_d = '0;
            else if (bus.pwdata3[1]) count_d = interval_q;
            else                     count_d = CNT_MAX;
            pre_cnt_d = '0;
            status_d  = '0;
        end else begin
            if (tick) count_d = cnt_step;
            if (clk_ctrl_q[0] && enabled) pre_cnt_d = pre_cnt_q + 15'd1;
            status_d = (clear_interrupt3 ? '0 : status_q) | (events & intr_en_q);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge pclk3) begin
        if (!n_p_reset3) begin
            clk_ctrl_q  <= '0;
            cntr_ctrl_q <= 6'b000001;
            interval_q  <= '0;
            intr_en_q   <= '0;
            match_q     <= '0;
            count_q     <= '0;
            pre_cnt_q   <= '0;
            status_q    <= '0;
        end else begin
            clk_ctrl_q  <= clk_ctrl_d;
            cntr_ctrl_q <= cntr_ctrl_d;
            interval_q  <= interval_d;
            intr_en_q   <= intr_en_d;
            match_q     <= match_d;
            count_q     <= count_d;
            pre_cnt_q   <= pre_cnt_d;
            status_q    <= status_d;
        end
    end

    assign counter_val_reg3  = count_q;
    assign clk_ctrl_reg3     = clk_ctrl_q;
    assign cntr_ctrl_reg3    = cntr_ctrl_q;
    assign interval_reg3     = interval_q;
    assign match_regs3       = match_q;
    assign interrupt_reg3    = status_q;
    assign interrupt_en_reg3 = intr_en_q;
    assign interrupt3        = |status_q;

endmodule

// File: tb/tb_ttc_timer_counter_param3.sv
// tb/tb_ttc_timer_counter_param3.sv - scoreboard bench for ttc_timer_counter_param3
module tb_ttc_timer_counter_param3;
    logic        pclk3 = 1'b0;
    logic        n_p_reset3;
    logic        clear_interrupt3;
    logic [15:0] counter_val_reg3;
    logic [4:0]  clk_ctrl_reg3;
    logic [5:0]  cntr_ctrl_reg3;
    logic [15:0] interval_reg3;
    logic [47:0] match_regs3;
    logic [4:0]  interrupt_reg3;
    logic [4:0]  interrupt_en_reg3;
    logic        interrupt3;

    typedef struct {
        logic [15:0] cnt;
        logic [4:0]  st;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    ttc_timer_counter_param3_if #(.CNT_W(16)) bus_if ();

    ttc_timer_counter_param3 #(.CNT_W(16), .NUM_MATCH(3)) dut (
        .pclk3             (pclk3),
        .n_p_reset3        (n_p_reset3),
        .bus               (bus_if),
        .clear_interrupt3  (clear_interrupt3),
        .counter_val_reg3  (counter_val_reg3),
        .clk_ctrl_reg3     (clk_ctrl_reg3),
        .cntr_ctrl_reg3    (cntr_ctrl_reg3),
        .interval_reg3     (interval_reg3),
        .match_regs3       (match_regs3),
        .interrupt_reg3    (interrupt_reg3),
        .interrupt_en_reg3 (interrupt_en_reg3),
        .interrupt3        (interrupt3)
    );

    always #5 pclk3 = ~pclk3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue the state expected after the coming edge
    task automatic cyc(input logic we, input logic [2:0] a, input logic [15:0] d, input logic clr,
                       input logic [15:0] ecnt, input logic [4:0] est);
        exp_t e;
        bus_if.wr_en3    = we;
        bus_if.wr_addr3  = a;
        bus_if.pwdata3   = d;
        clear_interrupt3 = clr;
        e.cnt = ecnt;
        e.st  = est;
        sb_q.push_back(e);
        @(negedge pclk3);
        bus_if.wr_en3    = 1'b0;
        clear_interrupt3 = 1'b0;
    endtask

    task automatic idle(input logic [15:0] ecnt, input logic [4:0] est);
        cyc(1'b0, 3'd0, 16'd0, 1'b0, ecnt, est);
    endtask

    initial begin
        forever begin
            @(posedge pclk3);
            #1;
            n_cyc++;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk($sformatf("count@%0d", n_cyc), 64'(counter_val_reg3), 64'(e.cnt));
                chk($sformatf("status@%0d", n_cyc), 64'(interrupt_reg3), 64'(e.st));
                chk($sformatf("irq@%0d", n_cyc), 64'(interrupt3), 64'(|e.st));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_p_reset3       = 1'b0;
        clear_interrupt3 = 1'b0;
        bus_if.wr_en3    = 1'b0;
        bus_if.wr_addr3  = 3'd0;
        bus_if.pwdata3   = 16'd0;
        repeat (3) @(negedge pclk3);

        chk("rst_count",    64'(counter_val_reg3),  64'h0);
        chk("rst_clk_ctrl", 64'(clk_ctrl_reg3),     64'h0);
        chk("rst_cntr",     64'(cntr_ctrl_reg3),    64'h01);
        chk("rst_interval", 64'(interval_reg3),     64'h0);
        chk("rst_match",    64'(match_regs3),       64'h0);
        chk("rst_status",   64'(interrupt_reg3),    64'h0);
        chk("rst_en",       64'(interrupt_en_reg3), 64'h0);
        chk("rst_irq",      64'(interrupt3),        64'h0);
        n_p_reset3 = 1'b1;

        // Up, interval mode, interval 5, no prescale
        cyc(1, 3'd2, 16'd5,  0, 16'd0, 5'h00);
        cyc(1, 3'd3, 16'h01, 0, 16'd0, 5'h00);
        cyc(1, 3'd1, 16'h02, 0, 16'd0, 5'h00);
        for (int i = 1; i <= 5; i++) idle(16'(i), 5'h00);
        idle(16'd0, 5'h01);
        idle(16'd1, 5'h01);
        cyc(0, 3'd0, 16'd0, 1, 16'd2, 5'h00);
        cyc(1, 3'd1, 16'h01, 0, 16'd3, 5'h00);
        idle(16'd3, 5'h00);
        chk("interval_reg", 64'(interval_reg3), 64'd5);
        chk("intr_en_reg",  64'(interrupt_en_reg3), 64'h01);

        // Prescale N=2, up overflow from 0xFFFE
        cyc(1, 3'd3, 16'h10, 0, 16'd3,    5'h00);
        cyc(1, 3'd1, 16'h15, 0, 16'hFFFF, 5'h00);
        chk("cntr_after_restart", 64'(cntr_ctrl_reg3), 64'h05);
        cyc(1, 3'd1, 16'h04, 0, 16'hFFFF, 5'h00);
        cyc(1, 3'd1, 16'h01, 0, 16'hFFFE, 5'h00);
        cyc(1, 3'd0, 16'h05, 0, 16'hFFFE, 5'h00);
        cyc(1, 3'd1, 16'h00, 0, 16'hFFFE, 5'h00);
        repeat (3) idle(16'hFFFE, 5'h00);
        repeat (4) idle(16'hFFFF, 5'h00);
        idle(16'h0000, 5'h10);
        idle(16'h0000, 5'h10);
        chk("clk_ctrl_reg", 64'(clk_ctrl_reg3), 64'h05);

        // Down, interval mode, one-shot with interval 3
        cyc(1, 3'd1, 16'h11, 0, 16'd0, 5'h00);
        cyc(1, 3'd0, 16'h00, 0, 16'd0, 5'h00);
        cyc(1, 3'd2, 16'd3,  0, 16'd0, 5'h00);
        cyc(1, 3'd3, 16'h01, 0, 16'd0, 5'h00);
        cyc(1, 3'd1, 16'h36, 0, 16'd3, 5'h00);
        chk("cntr_oneshot", 64'(cntr_ctrl_reg3), 64'h26);
        idle(16'd2, 5'h00);
        idle(16'd1, 5'h00);
        idle(16'd0, 5'h00);
        idle(16'd3, 5'h01);
        idle(16'd3, 5'h01);
        idle(16'd3, 5'h01);
        chk("cntr_oneshot_done", 64'(cntr_ctrl_reg3), 64'h27);

        // Match0 and match2 both at 4, clear on the same edge
        cyc(1, 3'd4, 16'd4,  0, 16'd3, 5'h01);
        cyc(1, 3'd6, 16'd4,  0, 16'd3, 5'h01);
        cyc(1, 3'd3, 16'h0A, 0, 16'd3, 5'h01);
        chk("match_regs", 64'(match_regs3), 64'h0004_0000_0004);
        cyc(1, 3'd1, 16'h18, 0, 16'd0, 5'h00);
        chk("cntr_match", 64'(cntr_ctrl_reg3), 64'h08);
        idle(16'd1, 5'h00);
        idle(16'd2, 5'h00);
        idle(16'd3, 5'h00);
        cyc(0, 3'd0, 16'd0, 1, 16'd4, 5'h0A);
        idle(16'd5, 5'h0A);
        cyc(0, 3'd0, 16'd0, 1, 16'd6, 5'h00);

        // Restart mid-run at 0x0100 with overflow status set
        cyc(1, 3'd1, 16'h09, 0, 16'd7,    5'h00);
        cyc(1, 3'd3, 16'h10, 0, 16'd7,    5'h00);
        cyc(1, 3'd1, 16'h15, 0, 16'hFFFF, 5'h00);
        cyc(1, 3'd1, 16'h00, 0, 16'hFFFF, 5'h00);
        for (int i = 1; i <= 257; i++) idle(16'(i - 1), 5'h10);
        cyc(1, 3'd1, 16'h10, 0, 16'd0, 5'h00);
        chk("cntr_restart", 64'(cntr_ctrl_reg3), 64'h00);
        idle(16'd1, 5'h00);

        // Reset mid-count, with a write on the same edge
        n_p_reset3      = 1'b0;
        bus_if.wr_en3   = 1'b1;
        bus_if.wr_addr3 = 3'd2;
        bus_if.pwdata3  = 16'h77;
        @(negedge pclk3);
        bus_if.wr_en3 = 1'b0;
        chk("mid_rst_count",    64'(counter_val_reg3), 64'h0);
        chk("mid_rst_cntr",     64'(cntr_ctrl_reg3),   64'h01);
        chk("mid_rst_interval", 64'(interval_reg3),    64'h0);
        chk("mid_rst_en",       64'(interrupt_en_reg3), 64'h0);
        chk("mid_rst_irq",      64'(interrupt3),       64'h0);
        n_p_reset3 = 1'b1;
        @(negedge pclk3);
        chk("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
